// File: rtl/reg_access_sequencer.sv
// Register-file initiator: read two operands, run the ALU handshake, write back with setup/strobe/hold.
// Optional ALU watchdog enabled by defining ALU_WATCHDOG_EN.
module reg_access_sequencer #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 5,
   parameter int ALU_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_ra,
   input  logic [ADDR_W-1:0] cmd_rb,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic              cmd_use_b,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [ADDR_W-1:0] regAddrA,
   output logic [ADDR_W-1:0] regAddrB,
   output logic [ADDR_W-1:0] regAddrD,
   output logic              regReA,
   output logic              regReB,
   output logic              regWeD,
   input  logic [DATA_W-1:0] busA,
   input  logic [DATA_W-1:0] busB,
   output logic [DATA_W-1:0] busD,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_start,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_EXEC, S_WSETUP, S_WSTROBE, S_WHOLD
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
   logic                use_b_q, use_b_d;
   logic [DATA_W-1:0]   imm_q, imm_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                first_q, first_d;
`ifdef ALU_WATCHDOG_EN
   logic [7:0]          wd_cnt_q, wd_cnt_d;
`endif

   // The EXEC cycle counter is 8 bits wide, so the timeout must fit it.
   if (ALU_TIMEOUT < 1 || ALU_TIMEOUT > 256) begin : g_bad_timeout
      $error("ALU_TIMEOUT must be in 1..256");
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ra_q     <= '0;
         rb_q     <= '0;
         rd_q     <= '0;
         use_b_q  <= 1'b0;
         imm_q    <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         result_q <= '0;
         first_q  <= 1'b0;
`ifdef ALU_WATCHDOG_EN
         wd_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rd_q     <= rd_d;
         use_b_q  <= use_b_d;
         imm_q    <= imm_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         result_q <= result_d;
         first_q  <= first_d;
`ifdef ALU_WATCHDOG_EN
         wd_cnt_q <= wd_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      rd_d      = rd_q;
      use_b_d   = use_b_q;
      imm_d     = imm_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      result_d  = result_q;
      first_d   = first_q;
`ifdef ALU_WATCHDOG_EN
      wd_cnt_d  = wd_cnt_q;
`endif
      cmd_ready = 1'b0;
      regReA    = 1'b0;
      regReB    = 1'b0;
      regWeD    = 1'b0;
      alu_start = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               ra_d    = cmd_ra;
               rb_d    = cmd_rb;
               rd_d    = cmd_rd;
               use_b_d = cmd_use_b;
               imm_d   = cmd_imm;
               state_d = S_READ;
            end
         end
         S_READ: begin
            regReA  = 1'b1;
            regReB  = use_b_q;
            alu_a_d = busA;
            alu_b_d = use_b_q ? busB : imm_q;
            first_d = 1'b1;
`ifdef ALU_WATCHDOG_EN
            wd_cnt_d = '0;
`endif
            state_d = S_EXEC;
         end
         S_EXEC: begin
            alu_start = first_q;
            first_d   = 1'b0;
            if (alu_done) begin
               result_d = alu_result;
               // r0 is never written: finish straight from EXEC.
               if (rd_q != '0) begin
                  state_d = S_WSETUP;
               end else begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
            end
`ifdef ALU_WATCHDOG_EN
            else if (wd_cnt_q == 8'(ALU_TIMEOUT - 1)) begin
               err     = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + 8'd1;
            end
`endif
         end
         S_WSETUP:  state_d = S_WSTROBE;
         S_WSTROBE: begin
            regWeD  = 1'b1;
            state_d = S_WHOLD;
         end
         S_WHOLD: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   assign regAddrA = ra_q;
   assign regAddrB = rb_q;
   assign regAddrD = rd_q;
   assign busD     = result_q;
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;

endmodule
